// File: rtl/input_conditioner_pkg.sv
// Shared types and elaboration-time helpers for the input conditioner.
package cond_pkg;

    // Per-channel debounce state: released, debouncing a press,
    // held, debouncing a release.
    typedef enum logic [1:0] {
        REL      = 2'd0,
        REL_BNC  = 2'd1,
        HELD     = 2'd2,
        HELD_BNC = 2'd3
    } cond_state_t;

    // Width of a counter that must be able to hold the value DB_CYCLES.
    function automatic int db_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

    // Range check for the channel parameters.
    // Both tick thresholds and the repeat period must fit the tick counters.
    function automatic bit params_ok(
        input int db_cycles,
        input int tick_w,
        input int long_ticks,
        input int rep_delay,
        input int rep_period
    );
        int tick_max;
        tick_max = (1 << tick_w) - 1;
        return (db_cycles >= 1) && (tick_w >= 1) && (tick_w <= 30) &&
               (long_ticks >= 1) && (long_ticks <= tick_max) &&
               (rep_delay >= 1) && (rep_delay <= tick_max) &&
               (rep_period >= 1) && (rep_period <= tick_max);
    endfunction

endpackage

// File: rtl/input_conditioner_channel.sv
// One input channel: synchroniser, debounce FSM, press/release pulses,
// long-press detection and tick-timed auto-repeat.
module cond_channel
    import cond_pkg::*;
#(
    parameter bit INV        = 1'b0,
    parameter int DB_CYCLES  = 250000,
    parameter int DB_W       = db_width(DB_CYCLES),
    parameter int TICK_W     = 8,
    parameter int LONG_TICKS = 60,
    parameter int REP_DELAY  = 30,
    parameter int REP_PERIOD = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    input  logic tick,
    input  logic repeat_en,
    output logic level,
    output logic press,
    output logic release_p,
    output logic long_press,
    output logic repeat_p
);

    if (!params_ok(DB_CYCLES, TICK_W, LONG_TICKS, REP_DELAY, REP_PERIOD)) begin : g_param_check
        $error("cond_channel: parameter out of range");
    end

    // The sample that starts a debounce already counts as the first agreeing one,
    // so a single-cycle debounce completes straight from REL/HELD.
    localparam bit                FIRST_DONE   = (DB_CYCLES == 1);
    localparam logic [DB_W-1:0]   DB_TARGET    = DB_W'(DB_CYCLES);
    localparam logic [TICK_W-1:0] HOLD_MAX     = '1;
    localparam logic [TICK_W-1:0] LONG_V       = TICK_W'(LONG_TICKS);
    localparam logic [TICK_W-1:0] REP_DELAY_V  = TICK_W'(REP_DELAY);
    localparam logic [TICK_W-1:0] REP_PERIOD_V = TICK_W'(REP_PERIOD);

    logic              sync1_reg, sync2_reg;
    logic              s;
    cond_state_t       state_reg, state_next;
    logic [DB_W-1:0]   db_cnt_reg, db_cnt_next, db_inc;
    logic              db_done;
    logic              held_now, held_next;
    logic [TICK_W-1:0] hold_cnt_reg, hold_inc, rep_cnt_reg, rep_inc;
    logic              count_en, hold_sat, long_hit, rep_phase, rep_fire;
    logic              level_reg, press_reg, release_reg, long_reg, repeat_reg;

    // Two-flop synchroniser on the pin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    assign s       = sync2_reg ^ INV;
    assign db_inc  = db_cnt_reg + DB_W'(1);
    assign db_done = (db_inc == DB_TARGET);

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= REL;
            db_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            db_cnt_reg <= db_cnt_next;
        end
    end

    // Next-state logic: a debounce completes after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        state_next  = state_reg;
        db_cnt_next = db_cnt_reg;
        case (state_reg)
            REL: begin
                if (s) begin
                    state_next  = FIRST_DONE ? HELD : REL_BNC;
                    db_cnt_next = FIRST_DONE ? '0 : DB_W'(1);
                end
            end
            REL_BNC: begin
                if (!s) begin
                    state_next  = REL;
                    db_cnt_next = '0;
                end else if (db_done) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_inc;
                end
            end
            HELD: begin
                if (!s) begin
                    state_next  = FIRST_DONE ? REL : HELD_BNC;
                    db_cnt_next = FIRST_DONE ? '0 : DB_W'(1);
                end
            end
            HELD_BNC: begin
                if (s) begin
                    state_next  = HELD;
                    db_cnt_next = '0;
                end else if (db_done) begin
                    state_next  = REL;
                    db_cnt_next = '0;
                end else begin
                    db_cnt_next = db_inc;
                end
            end
            default: begin
                state_next  = REL;
                db_cnt_next = '0;
            end
        endcase
    end

    // Output decode: pressed level and hold/repeat tick evaluation.
    always_comb begin
        held_now  = (state_reg == HELD) || (state_reg == HELD_BNC);
        held_next = (state_next == HELD) || (state_next == HELD_BNC);
        // Ticks count only once the level is visibly high and the channel stays pressed,
        // so a tick on the rising or the releasing edge is dropped.
        count_en  = tick && level_reg && held_now && held_next;
        hold_sat  = (hold_cnt_reg == HOLD_MAX);
        hold_inc  = hold_cnt_reg + TICK_W'(1);
        long_hit  = !hold_sat && (hold_inc == LONG_V);
        rep_phase = (hold_cnt_reg >= REP_DELAY_V);
        rep_inc   = rep_cnt_reg + TICK_W'(1);
        rep_fire  = rep_phase ? (rep_inc == REP_PERIOD_V) : (hold_inc == REP_DELAY_V);
    end

    // Registered level with one-cycle press/release pulses aligned to the level change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_reg   <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            level_reg   <= held_now;
            press_reg   <= held_now && !level_reg;
            release_reg <= !held_now && level_reg;
        end
    end

    // Hold and repeat tick counters; both reset whenever the channel is not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_reg <= '0;
            rep_cnt_reg  <= '0;
            long_reg     <= 1'b0;
            repeat_reg   <= 1'b0;
        end else begin
            long_reg   <= 1'b0;
            repeat_reg <= 1'b0;
            if (!held_next) begin
                hold_cnt_reg <= '0;
                rep_cnt_reg  <= '0;
            end else if (count_en) begin
                if (!hold_sat) begin
                    hold_cnt_reg <= hold_inc;
                end
                long_reg   <= long_hit;
                repeat_reg <= rep_fire && repeat_en;
                if (rep_fire) begin
                    rep_cnt_reg <= '0;
                end else if (rep_phase) begin
                    rep_cnt_reg <= rep_inc;
                end
            end
        end
    end

    assign level      = level_reg;
    assign press      = press_reg;
    assign release_p  = release_reg;
    assign long_press = long_reg;
    assign repeat_p   = repeat_reg;

endmodule

// File: rtl/input_conditioner.sv
// Multi-channel button/switch conditioner: one independent cond_channel per input pin.
module input_conditioner
    import cond_pkg::*;
#(
    parameter int              N_CH       = 4,
    parameter logic [N_CH-1:0] INV_MASK   = {N_CH{1'b0}},
    parameter int              DB_CYCLES  = 250000,
    parameter int              TICK_W     = 8,
    parameter int              LONG_TICKS = 60,
    parameter int              REP_DELAY  = 30,
    parameter int              REP_PERIOD = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    input  logic            tick,
    input  logic [N_CH-1:0] repeat_en,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p
);

    localparam int DB_W = db_width(DB_CYCLES);

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        cond_channel #(
            .INV        (INV_MASK[gi]),
            .DB_CYCLES  (DB_CYCLES),
            .DB_W       (DB_W),
            .TICK_W     (TICK_W),
            .LONG_TICKS (LONG_TICKS),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .raw        (raw_in[gi]),
            .tick       (tick),
            .repeat_en  (repeat_en[gi]),
            .level      (level[gi]),
            .press      (press[gi]),
            .release_p  (release_p[gi]),
            .long_press (long_press[gi]),
            .repeat_p   (repeat_p[gi])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected output events are queued per edge
// when stimulus is planned and compared every cycle.
module tb_input_conditioner;

    localparam int DB     = 4;
    localparam int LONG_T = 5;
    localparam int REP_D  = 3;
    localparam int REP_P  = 2;
    localparam int TPER   = 10;

    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_LONG  = 2;
    localparam int K_REP   = 3;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic [3:0] raw_in, repeat_en;
    logic [3:0] level, press, release_p, long_press, repeat_p;

    ev_t        sb_q[$];
    logic [3:0] exp_level;
    int         edge_n;
    int         tests;
    int         fails;

    input_conditioner #(
        .N_CH       (4),
        .INV_MASK   (4'b1000),
        .DB_CYCLES  (DB),
        .TICK_W     (8),
        .LONG_TICKS (LONG_T),
        .REP_DELAY  (REP_D),
        .REP_PERIOD (REP_P)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .raw_in     (raw_in),
        .tick       (tick),
        .repeat_en  (repeat_en),
        .level      (level),
        .press      (press),
        .release_p  (release_p),
        .long_press (long_press),
        .repeat_p   (repeat_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s @edge %0d: observed %b expected %b", tag, cyc, obs, expv);
        end
    endtask

    task automatic push(input int cyc, input int ch, input int kind);
        sb_q.push_back('{cyc: cyc, ch: ch, kind: kind});
    endtask

    // Raw level first sampled at edge k shows up on level/press after edge k+2+DB.
    task automatic push_press(input int ch, input int k);
        push(k + 2 + DB, ch, K_PRESS);
    endtask

    task automatic push_release(input int ch, input int k);
        push(k + 2 + DB, ch, K_REL);
    endtask

    // Ticks strictly after the press edge p and before the release edge r count;
    // long on the LONG_T-th, repeat on REP_D-th then every REP_P-th.
    task automatic hold_expect(input int ch, input int p, input int r, input bit rep_on);
        int n;
        n = 0;
        for (int t = (p / TPER + 1) * TPER; t < r; t += TPER) begin
            n++;
            if (n == LONG_T) push(t, ch, K_LONG);
            if (rep_on && n >= REP_D && ((n - REP_D) % REP_P) == 0) push(t, ch, K_REP);
        end
    endtask

    task automatic sb_check(input int cyc);
        logic [3:0] e_press, e_rel, e_long, e_rep;
        e_press = '0;
        e_rel   = '0;
        e_long  = '0;
        e_rep   = '0;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                case (sb_q[i].kind)
                    K_PRESS: begin e_press[sb_q[i].ch] = 1'b1; exp_level[sb_q[i].ch] = 1'b1; end
                    K_REL:   begin e_rel[sb_q[i].ch]   = 1'b1; exp_level[sb_q[i].ch] = 1'b0; end
                    K_LONG:  e_long[sb_q[i].ch] = 1'b1;
                    default: e_rep[sb_q[i].ch]  = 1'b1;
                endcase
                sb_q.delete(i);
            end
        end
        chk("level",      cyc, level,      exp_level);
        chk("press",      cyc, press,      e_press);
        chk("release_p",  cyc, release_p,  e_rel);
        chk("long_press", cyc, long_press, e_long);
        chk("repeat_p",   cyc, repeat_p,   e_rep);
    endtask

    // One clock: drive tick for the coming edge, then check just after it.
    task automatic step();
        tick = (((edge_n + 1) % TPER) == 0);
        @(posedge clk);
        edge_n++;
        #1;
        sb_check(edge_n);
    endtask

    // Advance so that the next input change is sampled at edge k.
    task automatic goto_edge(input int k);
        while (edge_n < k - 1) step();
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        edge_n    = 0;
        exp_level = '0;
        rst_n     = 1'b0;
        raw_in    = 4'b1000;
        repeat_en = 4'b0111;
        tick      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_level",   0, level,      4'b0000);
        chk("reset_press",   0, press,      4'b0000);
        chk("reset_release", 0, release_p,  4'b0000);
        chk("reset_long",    0, long_press, 4'b0000);
        chk("reset_repeat",  0, repeat_p,   4'b0000);
        rst_n = 1'b1;

        // Clean press on ch0, released so release_p lands on a tick edge.
        push_press(0, 10);
        push_release(0, 34);
        hold_expect(0, 16, 40, 1'b1);
        goto_edge(10); raw_in[0] = 1'b1;
        goto_edge(34); raw_in[0] = 1'b0;

        // ch1: 3-cycle glitch is rejected, then a 4-cycle high is accepted.
        goto_edge(50); raw_in[1] = 1'b1;
        goto_edge(53); raw_in[1] = 1'b0;
        push_press(1, 60);
        push_release(1, 64);
        hold_expect(1, 66, 70, 1'b1);
        goto_edge(60); raw_in[1] = 1'b1;
        goto_edge(64); raw_in[1] = 1'b0;

        // ch2 long hold with auto-repeat.
        push_press(2, 80);
        push_release(2, 174);
        hold_expect(2, 86, 180, 1'b1);
        goto_edge(80);  raw_in[2] = 1'b1;
        goto_edge(174); raw_in[2] = 1'b0;

        // ch3 active-low pin with repeat disabled: long_press only.
        push_press(3, 190);
        push_release(3, 394);
        hold_expect(3, 196, 400, 1'b0);
        goto_edge(190); raw_in[3] = 1'b0;
        goto_edge(394); raw_in[3] = 1'b1;

        // ch0 pressed so the level rises on a tick edge; that tick is ignored.
        push_press(0, 404);
        hold_expect(0, 410, 461, 1'b1);
        goto_edge(404); raw_in[0] = 1'b1;
        goto_edge(461);

        // Asynchronous reset while ch0 is held and repeating.
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_level",   edge_n, level,      4'b0000);
        chk("async_press",   edge_n, press,      4'b0000);
        chk("async_release", edge_n, release_p,  4'b0000);
        chk("async_long",    edge_n, long_press, 4'b0000);
        chk("async_repeat",  edge_n, repeat_p,   4'b0000);
        exp_level = '0;
        step();
        step();
        rst_n = 1'b1;

        // Still-held ch0 re-debounces into a fresh press with no release_p.
        push_press(0, 463);
        push_release(0, 484);
        hold_expect(0, 469, 490, 1'b1);
        goto_edge(484); raw_in[0] = 1'b0;
        goto_edge(500);

        tests++;
        assert (sb_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
